// File: rtl/streak_velocity_estimator_if.sv
// Pixel-stream input and velocity-result handshake bundle for streak_velocity_estimator.
interface streak_velocity_estimator_if #(
    parameter int X_W   = 11,
    parameter int Y_W   = 10,
    parameter int CNT_W = 16,
    parameter int OUT_W = 16
);
    logic                    valid_in;
    logic                    light_in;
    logic [X_W-1:0]          x_in;
    logic [Y_W-1:0]          y_in;
    logic                    frame_start_in;
    logic signed [OUT_W-1:0] vx_out;
    logic signed [OUT_W-1:0] vy_out;
    logic [CNT_W-1:0]        len_out;
    logic                    valid_out;
    logic                    ready_in;
    logic                    busy_out;
    logic [15:0]             drop_count_out;

    modport master (
        output valid_in, light_in, x_in, y_in, frame_start_in, ready_in,
        input  vx_out, vy_out, len_out, valid_out, busy_out, drop_count_out
    );

    modport slave (
        input  valid_in, light_in, x_in, y_in, frame_start_in, ready_in,
        output vx_out, vy_out, len_out, valid_out, busy_out, drop_count_out
    );
endinterface

// File: rtl/streak_velocity_estimator.sv
// Finds horizontal lit-pixel streaks and reports signed displacement per lit pixel.
// Define STREAK_FRAC_EN for fixed-point results carrying FRAC_BITS fractional bits.
module streak_velocity_estimator #(
    parameter int X_W       = 11,
    parameter int Y_W       = 10,
    parameter int CNT_W     = 16,
    parameter int OUT_W     = 16,
    parameter int MIN_RUN   = 2,
    parameter int FRAC_BITS = 4
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    streak_velocity_estimator_if.slave bus
);
    localparam int BASE_W = ((X_W > Y_W) ? X_W : Y_W) + 1;
`ifdef STREAK_FRAC_EN
    localparam int SH = FRAC_BITS;
`else
    localparam int SH = 0 * FRAC_BITS;
`endif
    localparam int NW     = BASE_W + SH;
    localparam int WIDE   = (OUT_W > NW + 1) ? OUT_W : NW + 1;
    localparam int STEP_W = $clog2(NW + 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(NW);
    localparam logic [CNT_W-1:0]  CNT_MIN   = CNT_W'(MIN_RUN);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {IDLE, RUN, DIV, OUT} state_t;

    state_t state, state_nxt;

    logic [X_W-1:0]   x_first, x_last, x_last_eff;
    logic [Y_W-1:0]   y_first, y_last, y_last_eff;
    logic [CNT_W-1:0] count, count_inc, count_eff, divisor;
    logic [STEP_W-1:0] step;
    logic [15:0]      drop_cnt;

    logic [NW-1:0]    q_x, q_y, q_x_nxt, q_y_nxt, dvd_x, dvd_y;
    logic [CNT_W-1:0] rem_x, rem_y, rem_x_nxt, rem_y_nxt;
    logic [CNT_W:0]   shx, shy;
    logic             ge_x, ge_y, neg_x, neg_y;
    logic signed [BASE_W-1:0] dx, dy;

    logic signed [OUT_W-1:0] vx_r, vy_r;
    logic [CNT_W-1:0]        len_r;

    logic pix_lit, start_run, extend_run, terminate, div_busy, div_done;

    function automatic logic [BASE_W-1:0] magnitude(input logic signed [BASE_W-1:0] d);
        return d[BASE_W-1] ? BASE_W'(-d) : BASE_W'(d);
    endfunction

    // Truncation toward zero falls out of dividing magnitudes and negating afterwards.
    function automatic logic signed [OUT_W-1:0] apply_sign(input logic [NW-1:0] mag,
                                                           input logic        neg);
        logic [WIDE-1:0] w;
        w = WIDE'(mag);
        if (neg) w = -w;
        return $signed(OUT_W'(w));
    endfunction

    assign pix_lit   = bus.valid_in && bus.light_in;
    assign count_inc = count + 1'b1;
    assign div_busy  = (state == DIV) && (step != STEP_LAST);
    assign div_done  = (state == DIV) && (step == STEP_LAST);

    always_comb begin
        state_nxt  = state;
        start_run  = 1'b0;
        extend_run = 1'b0;
        terminate  = 1'b0;
        case (state)
            IDLE: begin
                if (pix_lit) begin
                    start_run = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (bus.frame_start_in) begin
                    start_run = pix_lit;
                    state_nxt = pix_lit ? RUN : IDLE;
                end else if (pix_lit) begin
                    extend_run = 1'b1;
                    if (count_inc == CNT_MAX) begin
                        terminate = (count_inc >= CNT_MIN);
                        state_nxt = (count_inc >= CNT_MIN) ? DIV : IDLE;
                    end
                end else if (bus.valid_in) begin
                    terminate = (count >= CNT_MIN);
                    state_nxt = (count >= CNT_MIN) ? DIV : IDLE;
                end
            end
            DIV: begin
                if (div_done) state_nxt = OUT;
            end
            OUT: begin
                if (bus.ready_in) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A force-terminating pixel is folded in combinationally so the divide starts on that edge.
    always_comb begin
        x_last_eff = extend_run ? bus.x_in : x_last;
        y_last_eff = extend_run ? bus.y_in : y_last;
        count_eff  = extend_run ? count_inc : count;
        dx    = $signed(BASE_W'(x_last_eff)) - $signed(BASE_W'(x_first));
        dy    = $signed(BASE_W'(y_last_eff)) - $signed(BASE_W'(y_first));
        dvd_x = NW'(magnitude(dx)) << SH;
        dvd_y = NW'(magnitude(dy)) << SH;
    end

    // Restoring divide step: the dividend shifts out of q_* as quotient bits shift in.
    always_comb begin
        shx       = {rem_x, q_x[NW-1]};
        shy       = {rem_y, q_y[NW-1]};
        ge_x      = shx >= {1'b0, divisor};
        ge_y      = shy >= {1'b0, divisor};
        rem_x_nxt = ge_x ? CNT_W'(shx - {1'b0, divisor}) : shx[CNT_W-1:0];
        rem_y_nxt = ge_y ? CNT_W'(shy - {1'b0, divisor}) : shy[CNT_W-1:0];
        q_x_nxt   = {q_x[NW-2:0], ge_x};
        q_y_nxt   = {q_y[NW-2:0], ge_y};
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state    <= IDLE;
            count    <= '0;
            step     <= '0;
            drop_cnt <= '0;
            vx_r     <= '0;
            vy_r     <= '0;
            len_r    <= '0;
        end else begin
            state <= state_nxt;
            if (start_run)              count <= CNT_W'(1);
            else if (extend_run)        count <= count_inc;
            else if (state_nxt == IDLE) count <= '0;
            if (terminate)     step <= '0;
            else if (div_busy) step <= step + 1'b1;
            if (div_done) begin
                vx_r  <= apply_sign(q_x, neg_x);
                vy_r  <= apply_sign(q_y, neg_y);
                len_r <= divisor;
            end
            if ((state == DIV || state == OUT) && bus.valid_in && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (start_run) begin
            x_first <= bus.x_in;
            y_first <= bus.y_in;
            x_last  <= bus.x_in;
            y_last  <= bus.y_in;
        end else if (extend_run) begin
            x_last <= bus.x_in;
            y_last <= bus.y_in;
        end
        if (terminate) begin
            q_x     <= dvd_x;
            q_y     <= dvd_y;
            rem_x   <= '0;
            rem_y   <= '0;
            neg_x   <= dx[BASE_W-1];
            neg_y   <= dy[BASE_W-1];
            divisor <= count_eff;
        end else if (div_busy) begin
            q_x   <= q_x_nxt;
            q_y   <= q_y_nxt;
            rem_x <= rem_x_nxt;
            rem_y <= rem_y_nxt;
        end
    end

    assign bus.vx_out         = vx_r;
    assign bus.vy_out         = vy_r;
    assign bus.len_out        = len_r;
    assign bus.valid_out      = (state == OUT);
    assign bus.busy_out       = (state == DIV) || (state == OUT);
    assign bus.drop_count_out = drop_cnt;
endmodule

// File: doc/streak_velocity_estimator.md
Name: streak_velocity_estimator

Overview:
- Watches the raster pixel stream and finds each horizontal run ("streak") of lit pixels.
- For each streak it records the first and last lit coordinates and the lit-pixel count.
- Computes signed per-pixel displacement (dx/count, dy/count) with an internal serial divider.
- Successor to the per-frame camera velocity stage: adds width parameters, signed results, a minimum-length filter, frame abort, drop accounting and a valid/ready output handshake.

Parameters:
- X_W, 11, x coordinate width
- Y_W, 10, y coordinate width
- CNT_W, 16, lit-pixel counter width
- OUT_W, 16, signed velocity output width
- MIN_RUN, 2, minimum lit count for a streak to produce a result (must be >=1)
- FRAC_BITS, 4, fractional bits of result; used only with the optional feature

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- valid_in  in  1  pixel strobe
- light_in  in  1  pixel is lit (qualified by valid_in)
- x_in  in  X_W  pixel x
- y_in  in  Y_W  pixel y
- frame_start_in  in  1  one-cycle pulse at frame start
- vx_out  out  OUT_W  signed dx/count
- vy_out  out  OUT_W  signed dy/count
- len_out  out  CNT_W  lit count of the reported streak
- valid_out  out  1  result valid
- ready_in  in  1  downstream accepts the result
- busy_out  out  1  high in DIV or OUT state
- drop_count_out  out  16  saturating count of valid_in pixels ignored while busy

Behaviour:
- Reset: sync active-high on clk_in. Clears state to IDLE and zeroes every output (vx_out, vy_out, len_out, valid_out, busy_out, drop_count_out). Reset has priority over everything, including mid-DIV and mid-OUT; any pending result is discarded.
- States:
  - IDLE: count=0.
  - RUN: accumulating a streak.
  - DIV: serial divide in progress.
  - OUT: holding a result.
- IDLE, on valid_in&&light_in: store x_first/y_first and x_last/y_last = input, count=1, go to RUN.
- RUN, on valid_in&&light_in: update x_last/y_last, count+1. If count reaches 2^CNT_W-1, the run is force-terminated on that same pixel.
- Run termination: RUN plus valid_in&&!light_in, or forced termination.
  - count<MIN_RUN: discard, go to IDLE, no output.
  - Otherwise go to DIV.
- Arithmetic:
  - dx = x_last-x_first, dy = y_last-y_first, as signed (X_W+1)/(Y_W+1)-bit differences.
  - Divide magnitudes by count using a restoring divider, 1 quotient bit per cycle, x and y in parallel.
  - Apply the sign; truncate toward zero; sign-extend to OUT_W.
  - Divisor is never 0.
- Latency: terminating pixel sampled at edge N -> valid_out high after edge N+K+1, where K = max(X_W,Y_W)+1 (+FRAC_BITS when the feature is enabled).
- OUT:
  - vx_out/vy_out/len_out/valid_out stay stable while ready_in=0.
  - When valid_out&&ready_in at an edge: clear valid_out on that edge and go to IDLE.
  - The next streak can begin on the following pixel.
- DIV/OUT: valid_in pixels are ignored. Each one increments drop_count_out, saturating at 65535; the counter is cleared only by reset.
- frame_start_in:
  - In IDLE or RUN: abort the run (count=0, no output).
  - If it coincides with valid_in&&light_in, that pixel starts a new streak.
  - In DIV or OUT: ignored; the result is still delivered.
- Coordinates are not checked for monotonicity; negative dx/dy are legal.

Optional Feature:
- Macro: STREAK_FRAC_EN.
- Defined: dividends are |dx|<<FRAC_BITS and |dy|<<FRAC_BITS; results are fixed-point with FRAC_BITS fractional bits; K grows by FRAC_BITS.
- Undefined: integer quotient; FRAC_BITS unused.
- Defaults fit OUT_W without overflow in both modes.

Test Plan:
- Lit pixels at x=100,105,110,115,120, y=50,48,45,42,40, then one unlit pixel -> vx_out=4, vy_out=-2, len_out=5, valid_out exactly K+1 edges after the unlit pixel (K=12 integer). With STREAK_FRAC_EN: 64 and -32.
- Truncation: first/last x=10/17, count=2 -> vx=3; x=17/10 -> vx=-3; equal coordinates -> vx=0.
- Single lit pixel then unlit, MIN_RUN=2 -> no valid_out, state returns to IDLE, next streak reported normally.
- Hold ready_in=0 for 10 cycles while driving 6 valid_in pixels -> outputs stable, drop_count_out=6. Raise ready_in -> valid_out falls after one edge.
- frame_start_in mid-RUN (count=3), coincident with a lit pixel at (7,9) -> old run dropped; new streak's first=(7,9), len counts from 1.
- rst_in asserted during DIV -> next cycle all outputs 0, IDLE; a subsequent streak is computed correctly.
